// File: rtl/bcd_7seg_scan.sv
// Multiplexed 7-segment driver for a chain of BCD digits. It keeps a shadow copy of the
// digits and scans one position per slot. Each slot begins with a one-clock anti-ghosting blank.
module bcd_7seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

  // Active-high a..g pattern; codes above 9 render as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] pat);
    return pat ^ SEG_OFF;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;

  logic [6:0]              seg_p1;
  logic [NUM_DIGITS-1:0]   dig_p1;
  logic                    frame_tick_p1;

  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              cur_code;
  logic                    cur_zero_above;
  logic                    lz_blank;

  // zero_above[i]: digit i and every digit above it are zero (invalid codes count as non-zero)
  always_comb begin
    logic run;
    zero_above = '0;
    run        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run && (shadow_p0[4*i +: 4] == 4'd0);
      zero_above[i] = run;
    end
  end

  always_comb begin
    cur_code       = 4'd0;
    cur_zero_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        cur_code       = shadow_p0[4*i +: 4];
        cur_zero_above = zero_above[i];
      end
    end
    lz_blank = blank_lz && (idx_p0 != '0) && cur_zero_above;
  end

  // p0 -> p1: scan state and shadow feed the registered display outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_p0     <= '0;
      cnt_p0        <= '0;
      idx_p0        <= '0;
      seg_p1        <= SEG_OFF;
      dig_p1        <= DIG_OFF;
      frame_tick_p1 <= 1'b0;
    end else begin
      if (load)
        shadow_p0 <= bcd_in;

      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end

      frame_tick_p1 <= (cnt_p0 == CNT_LAST) && (idx_p0 == IDX_LAST);

      if (cnt_p0 == '0) begin
        seg_p1 <= SEG_OFF;
        dig_p1 <= DIG_OFF;
      end else begin
        dig_p1 <= (DIG_ONE << idx_p0) ^ DIG_OFF;
        seg_p1 <= lz_blank ? SEG_OFF : seg_polarity(seg_decode(cur_code));
      end
    end
  end

  assign seg        = seg_p1;
  assign dig        = dig_p1;
  assign frame_tick = frame_tick_p1;

endmodule
